// File: rtl/app_pkg.sv
// Shared definitions for the CDC loopback application.
// Holds the sleep FSM state type, default parameter values and the ASCII
// constants used by the optional upper-casing path.
package app_pkg;

  typedef enum logic [1:0] {
    StActive,
    StCount,
    StSleep
  } sleep_state_e;

  localparam int unsigned DefaultDepth      = 16;
  localparam int unsigned DefaultIdleCycles = 2000;

  localparam logic [7:0] AsciiLowerA     = 8'h61;
  localparam logic [7:0] AsciiLowerZ     = 8'h7A;
  localparam logic [7:0] AsciiCaseOffset = 8'h20;

  // Lower-case ASCII letters map to upper case; every other byte passes through.
  function automatic logic [7:0] ascii_upcase(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= AsciiLowerA && b <= AsciiLowerZ) begin
      r = b - AsciiCaseOffset;
    end
    return r;
  endfunction

endpackage

// File: rtl/app_fifo.sv
// Synchronous byte FIFO for the loopback application.
// Ports:
//   clk_i      application clock
//   rst_i      synchronous active-high reset (empties FIFO, zeroes pointers)
//   wr_en_i    write request; honoured when not full, or when full with a read
//   wr_data_i  byte to write
//   rd_en_i    read request; honoured when not empty
//   rd_data_o  head byte (combinational from storage)
//   full_o     occupancy == DEPTH
//   empty_o    occupancy == 0
//   count_o    occupancy, log2(DEPTH)+1 bits
module app_fifo
  import app_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop       = rd_en_i && !empty_o;
  // A write into a full FIFO is fine when the head leaves on the same edge.
  assign push      = wr_en_i && (!full_o || pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cdc_loopback_app.sv
// USB CDC loopback application: bytes arriving from the host (OUT) are
// buffered in a FIFO and echoed back (IN) through a single output register.
// A sleep FSM raises sleep_o after IDLE_CYCLES idle cycles.
// Build option: define CDC_LOOPBACK_UPCASE_EN to upper-case 'a'..'z' as they
// enter the output register; latency is the same either way.
// Ports:
//   clk_i        application clock (2 MHz)
//   rst_i        synchronous active-high reset
//   out_data_i   host-to-device byte
//   out_valid_i  out_data_i valid
//   out_ready_o  byte accepted this cycle (registered, FIFO not full)
//   in_data_o    device-to-host byte
//   in_valid_o   in_data_o valid
//   in_ready_i   consumer accepts in_data_o this cycle
//   sleep_o      block idle
module cdc_loopback_app
  import app_pkg::*;
#(
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned IDLE_CYCLES = DefaultIdleCycles
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sleep_o
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [15:0] IdleLast = 16'(IDLE_CYCLES - 1);

  logic          out_ready_q;
  logic          in_valid_q;
  logic [7:0]    in_data_q;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nxt;
  logic [7:0]    fifo_head, load_data;
  logic          push, pop, in_xfer;
  sleep_state_e  state_q, state_d;
  logic [15:0]   idle_cnt_q, idle_cnt_d;

  // out_ready_q is already low when full; the extra term keeps the FIFO safe.
  assign push    = out_valid_i && out_ready_q && !fifo_full;
  assign in_xfer = in_valid_q && in_ready_i;
  // Refill the output register whenever it is empty or its byte leaves now.
  assign pop     = !fifo_empty && (!in_valid_q || in_ready_i);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  app_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (push),
    .wr_data_i(out_data_i),
    .rd_en_i  (pop),
    .rd_data_o(fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

`ifdef CDC_LOOPBACK_UPCASE_EN
  assign load_data = ascii_upcase(fifo_head);
`else
  assign load_data = fifo_head;
`endif

  // Ready tracks the occupancy after this edge, so it is low only when full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_ready_q <= 1'b0;
    end else begin
      out_ready_q <= (count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_valid_q <= 1'b0;
      in_data_q  <= 8'h00;
    end else if (pop) begin
      in_valid_q <= 1'b1;
      in_data_q  <= load_data;
    end else if (in_xfer) begin
      in_valid_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      StActive: begin
        idle_cnt_d = '0;
        if (fifo_empty && !in_valid_q && !push && !in_xfer) begin
          state_d = StCount;
        end
      end
      StCount: begin
        if (out_valid_i) begin
          state_d    = StActive;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          state_d = StSleep;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      StSleep: begin
        if (out_valid_i) begin
          state_d    = StActive;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StActive;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StActive;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign out_ready_o = out_ready_q;
  assign in_valid_o  = in_valid_q;
  assign in_data_o   = in_data_q;
  assign sleep_o     = (state_q == StSleep);

endmodule

// File: tb/tb_cdc_loopback_app.sv
// Self-checking bench for cdc_loopback_app (DEPTH=16, IDLE_CYCLES=10).
// Accepted OUT bytes are pushed to a scoreboard queue, IN transfers pop and
// compare. Works in both builds (CDC_LOOPBACK_UPCASE_EN defined or not).
module tb_cdc_loopback_app;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic       sleep_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  cdc_loopback_app #(
    .DEPTH      (16),
    .IDLE_CYCLES(10)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .out_data_i (out_data_i),
    .out_valid_i(out_valid_i),
    .out_ready_o(out_ready_o),
    .in_data_o  (in_data_o),
    .in_valid_o (in_valid_o),
    .in_ready_i (in_ready_i),
    .sleep_o    (sleep_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] model(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef CDC_LOOPBACK_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7a) r = b - 8'h20;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Handshakes are sampled on the falling edge, i.e. what the next rising edge sees.
  initial begin
    logic       stall_q;
    logic [7:0] stall_data;
    stall_q    = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("stall_valid", in_valid_o, 1);
          check("stall_data", in_data_o, stall_data);
        end
        if (in_valid_o && in_ready_i) begin
          check("sb_underrun", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("in_data", in_data_o, exp_q.pop_front());
        end
        if (out_valid_i && out_ready_o) exp_q.push_back(model(out_data_i));
        stall_q    = in_valid_o && !in_ready_i;
        stall_data = in_data_o;
      end
    end
  end

  task automatic do_reset();
    rst_i       = 1'b1;
    out_valid_i = 1'b0;
    exp_q.delete();
    repeat (2) begin
      tick();
      check("rst_out_ready", out_ready_o, 0);
      check("rst_in_valid", in_valid_o, 0);
    end
    check("rst_in_data", in_data_o, 8'h00);
    check("rst_sleep", sleep_o, 0);
    rst_i = 1'b0;
    tick();
    check("post_rst_ready", out_ready_o, 1);
  endtask

  task automatic wait_drain();
    int n;
    n           = 0;
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    while ((exp_q.size() != 0 || in_valid_o) && n < 500) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 500, 1);
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v [3];
    v[0] = a; v[1] = b; v[2] = c;
    in_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_data_i  = v[i];
      out_valid_i = 1'b1;
      tick();
    end
    out_valid_i = 1'b0;
    wait_drain();
  endtask

  initial begin
    int sent, guard, cnt;
    logic acc;
    logic [7:0] d;

    // Reset values
    do_reset();

    // Latency and ordering with a ready consumer
    in_ready_i  = 1'b1;
    out_data_i  = 8'h41;
    out_valid_i = 1'b1;
    tick();
    check("lat_early", in_valid_o, 0);
    out_data_i = 8'h42;
    tick();
    check("lat_first_valid", in_valid_o, 1);
    check("lat_first_data", in_data_o, model(8'h41));
    out_data_i = 8'h43;
    tick();
    out_valid_i = 1'b0;
    wait_drain();

    // Fill to 17 bytes with the consumer stalled, then drain back to back
    in_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      out_data_i  = 8'h30 + 8'(i);
      out_valid_i = 1'b1;
      check("fill_ready", out_ready_o, 1);
      tick();
    end
    out_data_i = 8'h99;
    check("full_ready", out_ready_o, 0);
    tick();
    check("full_ready_hold", out_ready_o, 0);
    check("full_head_data", in_data_o, 8'h30);
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_rate", in_valid_o, 1);
      tick();
    end
    check("drained_valid", in_valid_o, 0);
    check("drained_ready", out_ready_o, 1);
    check("drained_sb", exp_q.size(), 0);

    // Random valid/ready traffic
    d     = 8'($urandom);
    sent  = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      out_valid_i = 1'($urandom_range(0, 1));
      out_data_i  = d;
      in_ready_i  = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      acc = out_valid_i && out_ready_o;
      tick();
      if (acc) begin
        sent++;
        d = 8'($urandom);
      end
      guard++;
    end
    check("rand_sent", sent, 1000);
    wait_drain();

    // Sleep entry and wake
    do_reset();
    for (int k = 2; k <= 11; k++) begin
      tick();
      if (k == 10) check("sleep_early", sleep_o, 0);
    end
    check("sleep_entered", sleep_o, 1);
    check("sleep_ready", out_ready_o, 1);
    out_data_i  = 8'h63;
    out_valid_i = 1'b1;
    in_ready_i  = 1'b1;
    tick();
    out_valid_i = 1'b0;
    check("wake", sleep_o, 0);
    wait_drain();

    // Case conversion (expected values follow the build)
    send_seq(8'h61, 8'h7A, 8'h31);
    send_seq(8'h60, 8'h7B, 8'h6D);

    // Reset with buffered bytes discards them
    in_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_data_i  = 8'hA0 + 8'(i);
      out_valid_i = 1'b1;
      tick();
    end
    out_valid_i = 1'b0;
    check("pre_rst_valid", in_valid_o, 1);
    do_reset();
    in_ready_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_valid_o) cnt++;
      tick();
    end
    check("stale_byte", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdc_loopback_app.md
CDC_LOOPBACK_APP -- requirements
Module: cdc_loopback_app

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; power of two, range 4..256.
REQ-002 Parameter IDLE_CYCLES, default 2000: idle clk_i cycles before sleep_o asserts (1 ms at 2 MHz); range 1..65535.
REQ-003 clk_i  input  1  application clock (2 MHz); single clock domain.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 out_data_i  input  8  host-to-device byte from usb_cdc.
REQ-006 out_valid_i  input  1  out_data_i valid.
REQ-007 out_ready_o  output  1  block accepts out_data_i this cycle.
REQ-008 in_data_o  output  8  device-to-host byte to usb_cdc.
REQ-009 in_valid_o  output  1  in_data_o valid.
REQ-010 in_ready_i  input  1  usb_cdc accepts in_data_o this cycle.
REQ-011 sleep_o  output  1  block idle; drives LED heartbeat at SoC level.

Function
REQ-012 OUT transfer occurs on a rising clk_i edge with out_valid_i=1 and out_ready_o=1; the byte is written to the FIFO.
REQ-013 out_ready_o is registered and equals 1 exactly when FIFO occupancy < DEPTH; full: out_ready_o=0 and out_data_i is ignored.
REQ-014 IN side is a single output register (skid stage); in_valid_o=1 while it holds a byte.
REQ-015 IN transfer occurs on an edge with in_valid_o=1 and in_ready_i=1.
REQ-016 While in_valid_o=1 and in_ready_i=0, in_data_o and in_valid_o hold stable.
REQ-017 Output register loads from the FIFO head when empty or transferring and FIFO is non-empty; back-to-back IN transfers sustain one byte per cycle.
REQ-018 Latency: byte accepted at edge N, with FIFO and output register empty, appears with in_valid_o=1 after edge N+1.
REQ-019 Simultaneous FIFO write and read at any occupancy, including full-at-read: occupancy unchanged; occupancy counter is log2(DEPTH)+1 bits and never wraps.
REQ-020 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-021 Byte order preserved; no drops, no duplicates.
REQ-022 Sleep FSM states: ACTIVE, COUNT, SLEEP.
REQ-023 ACTIVE->COUNT when FIFO empty, output register empty and no transfer this cycle.
REQ-024 COUNT increments a 16-bit idle counter each cycle; reaching IDLE_CYCLES-1 moves to SLEEP.
REQ-025 Any OUT transfer, or out_valid_i=1, in COUNT or SLEEP returns to ACTIVE next cycle and clears the counter.
REQ-026 sleep_o=1 exactly in SLEEP (registered); wake does not delay acceptance: out_ready_o is independent of sleep state.

Reset
REQ-027 rst_i=1 at an edge: FIFO empty, pointers 0, output register empty, FSM=ACTIVE, counter 0.
REQ-028 During and after reset: out_ready_o=0 while rst_i=1, 1 on first cycle after release; in_valid_o=0; in_data_o=8'h00; sleep_o=0.
REQ-029 Reset mid-transfer discards all buffered bytes; no partial byte is presented afterwards.

Configuration
REQ-030 Macro CDC_LOOPBACK_UPCASE_EN: when defined, bytes 8'h61..8'h7A are converted to 8'h41..8'h5A when loaded into the output register, all others unchanged; when undefined, bytes are echoed unmodified; latency identical in both builds.

Structure
REQ-031 Package app_pkg holds: sleep FSM state typedef, DEPTH/IDLE_CYCLES defaults, ASCII constants 'a', 'z', case offset 8'h20.
REQ-032 One sub-module app_fifo: synchronous FIFO (write, read, full, empty, count), parameterised by DEPTH, same clk_i/rst_i.

Verification
REQ-033 Send 8'h41,8'h42,8'h43 with in_ready_i=1 -> same bytes on in_data_o in order, first valid one cycle after first acceptance.
REQ-034 Hold in_ready_i=0, push 17 bytes at DEPTH=16 -> 16 accepted into FIFO plus 1 in output register, then out_ready_o=0; release in_ready_i -> all 17 drain in order, one per cycle.
REQ-035 Random 50% valid/ready toggling, 1000 bytes -> scoreboard match, in_data_o stable whenever stalled.
REQ-036 Idle from reset at IDLE_CYCLES=10 -> sleep_o=1 after 11 cycles; out_valid_i pulse -> sleep_o=0 next cycle, byte echoed.
REQ-037 Build with CDC_LOOPBACK_UPCASE_EN, send 8'h61,8'h7A,8'h31 -> 8'h41,8'h5A,8'h31; without macro -> unchanged.
REQ-038 Assert rst_i with 5 bytes buffered -> in_valid_o=0, out_ready_o=0 during reset, no stale byte appears after release.
